// File: rtl/param_shift_reg.sv
// Universal W-bit shift register: SIPO in either direction, parallel load for PISO, word-complete strobe.
// Latency: Q/BIT_CNT/WORD_VALID registered, one edge after the control inputs; SER_OUT is combinational from Q and DIR.
// Backpressure: none; EN=0 holds the register and bit count, and any pulse drops after one cycle.
//
// Ports:
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   en, dir, data_in     shift enable, direction (0: toward LSB, 1: toward MSB), serial input
//   load, par_in, clr    synchronous parallel load and clear (clr > load > shift > hold)
//   q, ser_out           register contents and serial output
//   bit_cnt, word_valid  bits in the current word, one-cycle complete-word strobe
//   parity               XOR of the last completed word (only with PARAM_SHIFT_REG_PARITY_EN)
//
// Optional feature macro: PARAM_SHIFT_REG_PARITY_EN

module param_shift_reg #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          dir,
  input  logic          data_in,
  input  logic          load,
  input  logic [W-1:0]  par_in,
  input  logic          clr,
  output logic [W-1:0]  q,
  output logic          ser_out,
  output logic [CW-1:0] bit_cnt,
`ifdef PARAM_SHIFT_REG_PARITY_EN
  output logic          word_valid,
  output logic          parity
`else
  output logic          word_valid
`endif
);

  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic [W-1:0] q_shift;
  logic         word_done;

  // Value Q takes if this edge shifts; computed unconditionally so the
  // parity path can reuse it.
  always_comb begin
    q_shift = q;
    if (dir) begin
      q_shift = {q[W-2:0], data_in};
    end else begin
      q_shift = {data_in, q[W-1:1]};
    end
  end

  // The shift arriving while the counter sits at W-1 completes the word.
  assign word_done = (bit_cnt == LAST_BIT);

  // The bit about to leave the register in the current direction.
  assign ser_out = dir ? q[W-1] : q[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q          <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      q          <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else if (load) begin
      q          <= par_in;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
    end else if (en) begin
      q          <= q_shift;
      // Wrap straight to 0 so back-to-back words need no gap cycle.
      bit_cnt    <= word_done ? '0 : bit_cnt + CW'(1);
      word_valid <= word_done;
    end else begin
      // Hold Q and count, but never stretch a pulse.
      word_valid <= 1'b0;
    end
  end

`ifdef PARAM_SHIFT_REG_PARITY_EN
  // Parity of the word Q will hold in the same cycle WORD_VALID rises;
  // it then holds until the next completed word, a load or a clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity <= 1'b0;
    end else if (clr || load) begin
      parity <= 1'b0;
    end else if (en && word_done) begin
      parity <= ^q_shift;
    end
  end
`endif

endmodule

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised universal shift register; next generation of the team's 4-bit SIPO.
- Operating modes:
  - serial-in/parallel-out in either direction;
  - parallel load for parallel-in/serial-out.
- Includes a bit counter that strobes WORD_VALID once per completed W-bit word.
- Sits between serial links and word-wide datapath logic in the lab designs.

Parameters:
- W, 8, register width in bits; legal range W >= 2.
- CW, $clog2(W), width of BIT_CNT; derived, not overridden.

Ports:
- CLK  input  1  rising-edge clock
- RESETN  input  1  asynchronous active-low reset
- EN  input  1  shift enable; a shift happens on a rising edge only when EN=1 and LOAD=0
- DIR  input  1  0: shift toward LSB (new bit enters MSB); 1: shift toward MSB (new bit enters LSB)
- DATA_IN  input  1  serial data in
- LOAD  input  1  synchronous parallel load
- PAR_IN  input  W  parallel load data
- CLR  input  1  synchronous clear
- Q  output  W  register contents
- SER_OUT  output  1  serial out; Q[0] when DIR=0, Q[W-1] when DIR=1; combinational from Q and DIR
- BIT_CNT  output  CW  bits shifted into the current word, 0..W-1
- WORD_VALID  output  1  one-cycle pulse: Q holds a complete shifted-in word

Behaviour:
- Reset: RESETN=0 asynchronously forces Q=0, BIT_CNT=0, WORD_VALID=0. SER_OUT therefore reads 0.
- Reset release: first active edge is the first CLK rising edge with RESETN=1.
- Per-edge priority, highest first: CLR > LOAD > shift (EN=1) > hold.
- CLR=1: Q=0, BIT_CNT=0, WORD_VALID=0.
- LOAD=1 (CLR=0): Q=PAR_IN, BIT_CNT=0, WORD_VALID=0. EN and DIR are ignored that cycle.
- Shift, DIR=0: Q <= {DATA_IN, Q[W-1:1]}.
- Shift, DIR=1: Q <= {Q[W-2:0], DATA_IN}.
- Counter on a shift:
  - BIT_CNT < W-1: BIT_CNT <= BIT_CNT+1, WORD_VALID <= 0.
  - BIT_CNT == W-1: BIT_CNT <= 0, WORD_VALID <= 1. The pulse is visible in the cycle in which Q holds the full word.
- Hold (EN=0, LOAD=0, CLR=0): Q and BIT_CNT unchanged, WORD_VALID <= 0. Pulses are never stretched.
- Back-to-back words with EN held high: WORD_VALID pulses every W cycles and BIT_CNT wraps with no gap cycle.
- DIR change mid-word: takes effect on the next shift. BIT_CNT is not reset.
- EN dropped mid-word: BIT_CNT is retained and counting resumes when EN returns.
- Reset asserted mid-word: all state cleared immediately, independent of CLK. The partial word is discarded.
- PISO use: LOAD, then W shifts; SER_OUT presents the loaded bits LSB-first (DIR=0) or MSB-first (DIR=1). WORD_VALID still pulses after W shifts.
- All outputs are registered except SER_OUT. No X may propagate from Q after reset.

Optional Feature:
- Macro: PARAM_SHIFT_REG_PARITY_EN.
- When defined:
  - Extra output PARITY, 1 bit, registered.
  - On each edge where WORD_VALID is set, PARITY <= XOR of the next-state Q. It holds until the next completed word, LOAD, CLR or reset; each of these clears it to 0.
- When undefined: the PARITY port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: RESETN=0 with random inputs -> Q=0, BIT_CNT=0, WORD_VALID=0, SER_OUT=0. Asserting RESETN asynchronously mid-cycle clears immediately.
- SIPO DIR=0, W=4, EN=1, DATA_IN 1,1,0,1 on four edges -> Q=4'b1011, BIT_CNT 1,2,3,0, WORD_VALID=1 in exactly the cycle after the 4th edge, 0 afterwards.
- SIPO DIR=1, W=8, bits 1,0,1,0,0,1,1,0 -> Q=8'hA6, one WORD_VALID pulse. 16 continuous bits -> two pulses exactly 8 cycles apart.
- PISO, W=8: LOAD with PAR_IN=8'hC5, then 8 shifts with DIR=0 -> SER_OUT sequence 1,0,1,0,0,0,1,1. LOAD together with EN=1 -> load wins, BIT_CNT=0.
- Priority/hold, W=4: CLR and LOAD both high with PAR_IN=4'hF -> Q=0. EN=0 after 2 bits -> BIT_CNT stays 2 and no pulse; resume 2 bits -> pulse.
- PARAM_SHIFT_REG_PARITY_EN defined, W=4: word 4'b1011 -> PARITY=1; next word 4'b1001 -> PARITY=0; CLR -> PARITY=0.
